// File: rtl/pipereg_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipereg_skid_pkg
// Brief  : Shared encodings and stage-boundary width defaults for the
//          pipeline-stage register with skid buffer.
// Rev    : 1.0  initial release
// ============================================================================
package pipereg_skid_pkg;

    // Occupancy encodings; the FSM state value is the occupancy output.
    localparam logic [1:0] PIPEREG_OCC_EMPTY = 2'd0;
    localparam logic [1:0] PIPEREG_OCC_ONE   = 2'd1;
    localparam logic [1:0] PIPEREG_OCC_FULL  = 2'd2;

    typedef enum logic [1:0] {
        OCC_EMPTY = PIPEREG_OCC_EMPTY,
        OCC_ONE   = PIPEREG_OCC_ONE,
        OCC_FULL  = PIPEREG_OCC_FULL
    } occ_e;

    // Default control/payload widths for each stage boundary.
    localparam int IF_ID_CTRL_W   = 8;
    localparam int IF_ID_DATA_W   = 64;
    localparam int ID_EXE_CTRL_W  = 32;
    localparam int ID_EXE_DATA_W  = 128;
    localparam int EXE_MEM_CTRL_W = 16;
    localparam int EXE_MEM_DATA_W = 96;
    localparam int MEM_WB_CTRL_W  = 8;
    localparam int MEM_WB_DATA_W  = 64;

endpackage : pipereg_skid_pkg
`default_nettype wire

// File: rtl/pipereg_skid_slot.sv
`default_nettype none
// ============================================================================
// Module : pipereg_slot
// Brief  : One {valid, ctrl, data} holding register. clear_all zeroes every
//          field, clear_ctrl zeroes valid and ctrl but keeps the payload,
//          load captures a new valid word. Priority: clear_all > clear_ctrl
//          > load.
// Rev    : 1.0  initial release
// ============================================================================
module pipereg_slot #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              load,
    input  logic              clear_ctrl,
    input  logic              clear_all,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Next-state select; ctrl is zeroed whenever the slot goes invalid.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear_all) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            data_d  = '0;
        end else if (clear_ctrl) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load) begin
            valid_d = 1'b1;
            ctrl_d  = ld_ctrl;
            data_d  = ld_data;
        end
    end

    // Slot register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign ctrl  = ctrl_q;
    assign data  = data_q;

endmodule : pipereg_slot
`default_nettype wire

// File: rtl/pipereg_skid.sv
`default_nettype none
// ============================================================================
// Module : pipereg_skid
// Brief  : Pipeline-stage register with valid/ready handshake and an
//          optional second (skid) entry so in_ready can come from a flop.
//          Holds the occupancy FSM, ready logic and bubble counter; the
//          storage lives in pipereg_slot instances (head, skid).
// Rev    : 1.0  initial release
// ============================================================================
module pipereg_skid
    import pipereg_skid_pkg::*;
#(
    parameter int DATA_W          = 128,
    parameter int CTRL_W          = 32,
    parameter int SKID            = 1,
    parameter int FLUSH_CTRL_ONLY = 1,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    occ_e              occ_q, occ_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;

    logic              push, pop;
    logic              head_load, head_clr_ctrl, head_clr_all;
    logic              skid_load, skid_clr;
    logic              head_valid;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] head_ld_ctrl;
    logic [DATA_W-1:0] head_ld_data;

    assign push = in_valid & in_ready;
    assign pop  = head_valid & out_ready;

    // The head refills from the skid entry when one is parked, else from in_*.
    assign head_ld_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    assign head_ld_data = skid_valid ? skid_data : in_data;

    // Occupancy FSM register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Next occupancy and slot controls; flush outranks the handshake and
    // drops any push in the same cycle.
    always_comb begin
        occ_d         = occ_q;
        head_load     = 1'b0;
        head_clr_ctrl = 1'b0;
        head_clr_all  = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        if (flush) begin
            occ_d         = OCC_EMPTY;
            head_clr_ctrl = 1'b1;
            head_clr_all  = (FLUSH_CTRL_ONLY == 0);
            skid_clr      = 1'b1;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_load = 1'b1;
                        occ_d     = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_load = 1'b1;
                    end else if (push) begin
                        skid_load = 1'b1;
                        occ_d     = OCC_FULL;
                    end else if (pop) begin
                        head_clr_ctrl = 1'b1;
                        occ_d         = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_load = 1'b1;
                        skid_clr  = 1'b1;
                        occ_d     = OCC_ONE;
                    end
                end
                default: begin
                    occ_d = OCC_EMPTY;
                end
            endcase
        end
    end

    pipereg_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_head (
        .clk        (clk),
        .nrst       (nrst),
        .load       (head_load),
        .clear_ctrl (head_clr_ctrl),
        .clear_all  (head_clr_all),
        .ld_ctrl    (head_ld_ctrl),
        .ld_data    (head_ld_data),
        .valid      (head_valid),
        .ctrl       (out_ctrl),
        .data       (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q, in_ready_d;

            // Ready is precomputed from the next state so it is a bare flop.
            always_comb begin
                in_ready_d = (occ_d != OCC_FULL);
            end

            // Registered upstream ready; no path from out_ready.
            always_ff @(posedge clk) begin
                if (!nrst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;

            pipereg_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk        (clk),
                .nrst       (nrst),
                .load       (skid_load),
                .clear_ctrl (skid_clr),
                .clear_all  (head_clr_all),
                .ld_ctrl    (in_ctrl),
                .ld_data    (in_data),
                .valid      (skid_valid),
                .ctrl       (skid_ctrl),
                .data       (skid_data)
            );
        end else begin : g_no_skid
            // Single register: accept when empty or when the head leaves now.
            assign in_ready   = ~head_valid | out_ready;
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
        end
    endgenerate

    // Saturating bubble count; only reset clears it, flush does not.
    always_comb begin
        bubble_d = bubble_q;
        if (out_ready && !head_valid && (bubble_q != CNT_MAX)) begin
            bubble_d = bubble_q + CNT_ONE;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign out_valid  = head_valid;
    assign occupancy  = occ_q;
    assign bubble_cnt = bubble_q;

endmodule : pipereg_skid
`default_nettype wire
